conv_mac_seq: RTL and testbench

- Sequences one convolution output point (a dot product of KERNEL_SIZE taps) through the shared unsigned shift-add multiplier.
- Sits directly upstream and downstream of that multiplier. Accepts a data window and kernel via a valid/ready handshake, then issues one start per tap on mul_*.
- Waits for each mul_finish pulse and accumulates the returned product.
- Presents the final sum on a valid/ready output to the conv write-back stage.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_mac_seq.sv | 152 +++++++++++++++
 tb/tb_conv_mac_seq.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution datapath blocks.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  // Accumulator width that can hold the sum of `taps` full-width products without overflow.
  function automatic int acc_len(input int len, input int taps);
    return 2 * len + $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_mac_seq.sv
// Sequences one convolution output point through a shared shift-add multiplier,
// one tap at a time, and hands the accumulated dot product downstream.
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int LEN         = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_LEN     = acc_len(LEN, KERNEL_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LEN*KERNEL_SIZE-1:0]  in_data,
  input  logic [LEN*KERNEL_SIZE-1:0]  in_kernel,
  output logic [LEN-1:0]              mul_a,
  output logic [LEN-1:0]              mul_b,
  output logic                        mul_start,
  input  logic [2*LEN-1:0]            mul_product,
  input  logic                        mul_finish,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_LEN-1:0]          out_sum,
  output logic                        busy
);

  localparam int VW = LEN * KERNEL_SIZE;
  localparam int CW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(KERNEL_SIZE - 1);

  mac_state_t         state_q, state_d;
  logic [CW-1:0]      tap_cnt_q, tap_cnt_d;
  logic [VW-1:0]      data_q, data_d;
  logic [VW-1:0]      kernel_q, kernel_d;
  logic [ACC_LEN-1:0] acc_q, acc_d;
  logic [ACC_LEN-1:0] out_sum_q, out_sum_d;
  logic [LEN-1:0]     mul_a_q, mul_a_d;
  logic [LEN-1:0]     mul_b_q, mul_b_d;
  logic               in_ready_q, in_ready_d;
  logic               mul_start_q, mul_start_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [CW-1:0]      tap_nxt;
  logic [ACC_LEN-1:0] acc_sum;

  assign tap_nxt = tap_cnt_q + CW'(1);
  assign acc_sum = acc_q + ACC_LEN'(mul_product);

  // Next-state, datapath and output decode; outputs are computed from state_d so they come straight off flops.
  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    data_d    = data_q;
    kernel_d  = kernel_q;
    acc_d     = acc_q;
    out_sum_d = out_sum_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d    = in_data;
          kernel_d  = in_kernel;
          acc_d     = '0;
          tap_cnt_d = '0;
          mul_a_d   = in_data[LEN-1:0];
          mul_b_d   = in_kernel[LEN-1:0];
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // The product is only valid during the finish pulse, so it is folded in on that exact cycle.
        if (mul_finish) begin
          acc_d = acc_sum;
          if (tap_cnt_q == LAST_TAP) begin
            out_sum_d = acc_sum;
            state_d   = DONE;
          end else begin
            tap_cnt_d = tap_nxt;
            mul_a_d   = data_q[int'(tap_nxt) * LEN +: LEN];
            mul_b_d   = kernel_q[int'(tap_nxt) * LEN +: LEN];
            state_d   = ISSUE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    mul_start_d = (state_d == ISSUE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      data_q      <= '0;
      kernel_q    <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      data_q      <= data_d;
      kernel_q    <= kernel_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      in_ready_q  <= in_ready_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Scoreboard bench for conv_mac_seq: randomised windows against a dot-product model,
// with a behavioural multiplier of configurable latency on the mul_* side.
module tb_conv_mac_seq;

  localparam int LEN = 8;
  localparam int K   = 3;
  localparam int ACC = conv_pkg::acc_len(LEN, K);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LEN*K-1:0]   in_data = '0;
  logic [LEN*K-1:0]   in_kernel = '0;
  logic [LEN-1:0]     mul_a, mul_b;
  logic               mul_start;
  logic [2*LEN-1:0]   mul_product = '0;
  logic               mul_finish = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [ACC-1:0]     out_sum;
  logic               busy;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  logic [ACC-1:0]     sb_q[$];
  logic [2*LEN-1:0]   op_q[$];

  conv_mac_seq #(.LEN(LEN), .KERNEL_SIZE(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_kernel(in_kernel),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_product(mul_product), .mul_finish(mul_finish),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: latency chosen per start, product only driven valid on the finish pulse.
  int   lat_mode = 0;
  int   lat_idx = 0;
  int   starts = 0;
  int   pend_cnt = 0;
  logic pend = 1'b0;
  logic spur_en = 1'b0;
  logic [LEN-1:0] pa, pb;
  int   lat_list[3] = '{1, 7, 40};

  always @(negedge clk) begin
    mul_finish  = 1'b0;
    mul_product = 16'($urandom);
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (mul_start) chk("start_one_cycle", 1, 0);
      if (pend_cnt <= 1) begin
        mul_finish  = 1'b1;
        mul_product = pa * pb;
        pend = 1'b0;
        chk("operands_held", {mul_a, mul_b}, {pa, pb});
      end else begin
        pend_cnt--;
      end
    end else if (mul_start) begin
      pa = mul_a;
      pb = mul_b;
      pend = 1'b1;
      starts++;
      case (lat_mode)
        1:       begin pend_cnt = lat_list[lat_idx % 3]; lat_idx++; end
        2:       pend_cnt = 40;
        default: pend_cnt = $urandom_range(1, 12);
      endcase
      if (op_q.size() == 0) chk("op_unexpected", 1, 0);
      else chk("mul_operands", {pa, pb}, op_q.pop_front());
    end else if (spur_en && out_valid) begin
      mul_finish = 1'b1;
    end
  end

  // Output monitor: every accepted result is matched against the oldest expected sum.
  int ov_cycles = 0;
  int out_hs_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) ov_cycles++;
      if (out_valid && out_ready) begin
        out_hs_cyc = cyc + 1;
        if (sb_q.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_sum", out_sum, sb_q.pop_front());
      end
    end
  end

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom);
  end

  int acc_cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned d[K], input int unsigned kk[K]);
    for (int i = 0; i < K; i++) begin
      in_data[i*LEN +: LEN]   = LEN'(d[i]);
      in_kernel[i*LEN +: LEN] = LEN'(kk[i]);
    end
  endtask

  // Presents a window, waits for acceptance, and records the model's expectations.
  task automatic send(input int unsigned d[K], input int unsigned kk[K]);
    longint unsigned sum;
    int n;
    load(d, kk);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 5000) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    sum = 0;
    for (int i = 0; i < K; i++) begin
      op_q.push_back({LEN'(d[i]), LEN'(kk[i])});
      sum += longint'(d[i]) * longint'(kk[i]);
    end
    sb_q.push_back(ACC'(sum));
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 20000) begin
      step();
      n++;
    end
    if (sb_q.size() != 0 || busy) chk("drain_timeout", 0, 1);
  endtask

  function automatic int unsigned rnd();
    return ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
  endfunction

  task automatic rand_win(output int unsigned d[K], output int unsigned kk[K]);
    for (int i = 0; i < K; i++) begin
      d[i]  = rnd();
      kk[i] = rnd();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned d[K];
    int unsigned kk[K];
    int unsigned d2[K];
    int unsigned k2[K];
    int s0, o0, n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, mul_start, mul_a, mul_b, out_valid, out_sum, busy},
        {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 18'd0, 1'b0});
    rst = 1'b0;
    step();

    // Basic window: three starts, one-cycle valid, known sum.
    out_ready = 1'b1;
    s0 = starts;
    o0 = ov_cycles;
    send('{1, 2, 3}, '{4, 5, 6});
    in_valid = 1'b0;
    drain();
    chk("t1_starts", starts - s0, 3);
    chk("t1_valid_cycles", ov_cycles - o0, 1);
    chk("t1_sum", out_sum, 32);

    // Full-scale operands must not truncate.
    send('{255, 255, 255}, '{255, 255, 255});
    in_valid = 1'b0;
    drain();
    chk("t2_sum", out_sum, 195075);

    // Backpressure in DONE with a second window waiting and a spurious finish.
    out_ready = 1'b0;
    rand_win(d, kk);
    send(d, kk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 2000) begin
      step();
      n++;
    end
    chk("t3_reach_done", out_valid, 1);
    rand_win(d2, k2);
    load(d2, k2);
    in_valid = 1'b1;
    spur_en = 1'b1;
    repeat (5) begin
      step();
      chk("t3_hold", {out_valid, in_ready, out_sum}, {1'b1, 1'b0, sb_q[0]});
    end
    spur_en = 1'b0;
    out_ready = 1'b1;
    send(d2, k2);
    in_valid = 1'b0;
    drain();

    // Variable multiplier latency with a spurious finish during DONE.
    lat_mode = 1;
    lat_idx = 0;
    spur_en = 1'b1;
    for (int w = 0; w < 2; w++) begin
      rand_win(d, kk);
      send(d, kk);
      in_valid = 1'b0;
      drain();
    end
    spur_en = 1'b0;
    lat_mode = 0;

    // Reset in the middle of tap 1's multiply.
    lat_mode = 2;
    s0 = starts;
    send('{5, 6, 7}, '{8, 9, 10});
    in_valid = 1'b0;
    n = 0;
    while (!((starts - s0) >= 2 && !mul_start) && n < 2000) begin
      step();
      n++;
    end
    step();
    rst = 1'b1;
    step();
    chk("t5_reset", {in_ready, out_valid, busy, mul_start}, {1'b1, 1'b0, 1'b0, 1'b0});
    sb_q.delete();
    op_q.delete();
    rst = 1'b0;
    lat_mode = 0;
    step();
    send('{2, 2, 2}, '{3, 3, 3});
    in_valid = 1'b0;
    drain();
    chk("t5_sum", out_sum, 18);

    // Back-to-back windows with in_valid held high.
    rand_win(d, kk);
    send(d, kk);
    rand_win(d2, k2);
    send(d2, k2);
    chk("t6_b2b_accept", acc_cyc - out_hs_cyc, 1);
    in_valid = 1'b0;
    drain();

    // Randomised traffic with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int w = 0; w < 25; w++) begin
      rand_win(d, kk);
      send(d, kk);
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
    end
    in_valid = 1'b0;
    drain();
    rand_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
